// File: rtl/approx_mul_err_sweep.sv
// Exhaustive 8x8 operand sweep with error statistics for an
// external approximate multiplier returning its product LAT cycles later.
module approx_mul_err_sweep #(
  parameter int LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [7:0]  op_a,
  output logic [7:0]  op_b,
  input  logic [15:0] prod_in,
  output logic        busy,
  output logic        done,
  output logic [16:0] sample_cnt,
  output logic [16:0] err_cnt,
  output logic [31:0] sum_ed,
  output logic [15:0] max_ed,
  output logic [7:0]  max_a,
  output logic [7:0]  max_b
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam int D = (LAT > 0) ? LAT : 1;
  localparam logic [2:0] DLAST = 3'(D - 1);

  state_t state, nxt;

  logic [15:0] idx;
  logic [2:0]  dcnt;
  logic        go;
  logic        issue;
  logic        last;

  logic [D-1:0] vsr;
  logic [15:0]  tsr [D];

  logic        cmp_v;
  logic [15:0] cmp_t;
  logic [15:0] exact;
  logic [16:0] diff;
  logic [16:0] diff_n;
  logic [15:0] ed;

  assign go    = start && (state == IDLE || state == DONE);
  assign issue = (state == RUN);
  assign last  = (idx == 16'hffff);

  assign op_a = idx[15:8];
  assign op_b = idx[7:0];
  assign busy = (state == RUN) || (state == DRAIN);
  assign done = (state == DONE);

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  if (start) nxt = RUN;
      RUN: begin
        if (last) nxt = (LAT == 0) ? DONE : DRAIN;
      end
      DRAIN: if (dcnt == DLAST) nxt = DONE;
      DONE:  if (start) nxt = RUN;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx  <= '0;
      dcnt <= '0;
    end else begin
      if (go)
        idx <= '0;
      else if (issue && !last)
        idx <= idx + 16'd1;
      if (state == DRAIN) dcnt <= dcnt + 3'd1;
      else                dcnt <= '0;
    end
  end

  // Tags ride alongside the multiplier latency so each product meets its operands
  always_ff @(posedge clk) begin
    if (rst) begin
      vsr <= '0;
      for (int i = 0; i < D; i++) tsr[i] <= '0;
    end else begin
      vsr[0] <= issue;
      tsr[0] <= idx;
      for (int i = 1; i < D; i++) begin
        vsr[i] <= vsr[i-1];
        tsr[i] <= tsr[i-1];
      end
    end
  end

  generate
    if (LAT == 0) begin : g_comb
      assign cmp_v = issue;
      assign cmp_t = idx;
    end else begin : g_pipe
      assign cmp_v = vsr[D-1];
      assign cmp_t = tsr[D-1];
    end
  endgenerate

  assign exact  = {8'h00, cmp_t[15:8]} * {8'h00, cmp_t[7:0]};
  assign diff   = {1'b0, exact} - {1'b0, prod_in};
  assign diff_n = -diff;
  assign ed     = diff[16] ? diff_n[15:0] : diff[15:0];

  always_ff @(posedge clk) begin
    if (rst || go) begin
      sample_cnt <= '0;
      err_cnt    <= '0;
      sum_ed     <= '0;
      max_ed     <= '0;
      max_a      <= '0;
      max_b      <= '0;
    end else if (cmp_v) begin
      sample_cnt <= sample_cnt + 17'd1;
      if (ed != 16'd0) err_cnt <= err_cnt + 17'd1;
      sum_ed <= sum_ed + {16'h0000, ed};
      if (ed > max_ed) begin
        max_ed <= ed;
        max_a  <= cmp_t[15:8];
        max_b  <= cmp_t[7:0];
      end
    end
  end

endmodule
